// File: rtl/p405s_icu_pkg.sv
// Shared definitions for the ICU line-fill sequencer: state encoding, PLB transfer sizes, line geometry.
package p405s_icu_pkg;
  localparam int LINE_DW = 4;

  localparam logic [1:0] TRANSIZE_LINE8 = 2'b10;
  localparam logic [1:0] TRANSIZE_SGL   = 2'b00;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_DATA,
    FS_DRAIN,
    FS_ABORT
  } fillState_t;
endpackage

// File: rtl/p405s_icu_fill_cnt.sv
// Beat counter, per-doubleword valid mask and sticky bus-error flag for one ICU line fill.
module p405s_icu_fill_cnt #(
  parameter int LINE_DW = p405s_icu_pkg::LINE_DW
) (
  input  logic       CB,
  input  logic       RST_ResetCore,
  input  logic       start,
  input  logic       lineFill,
  input  logic       beat,
  input  logic       wrBeat,
  input  logic [0:1] beatDw,
  input  logic       beatErr,
  output logic [1:0] beatCnt,
  output logic       lastBeat,
  output logic       errAny,
  output logic [0:3] dwValid
);
  localparam logic [1:0] LAST_LINE = 2'(LINE_DW - 1);

  logic lineQ;
  logic errQ;

  // Completion is seen on the beat itself so the done pulse lands one cycle later.
  assign lastBeat = beat & (beatCnt == (lineQ ? LAST_LINE : 2'd0));
  assign errAny   = errQ | (wrBeat & beatErr);

  always_ff @(posedge CB) begin
    if (RST_ResetCore) begin
      beatCnt <= 2'd0;
      lineQ   <= 1'b0;
      errQ    <= 1'b0;
      dwValid <= '0;
    end else if (start) begin
      beatCnt <= 2'd0;
      lineQ   <= lineFill;
      errQ    <= 1'b0;
      dwValid <= '0;
    end else begin
      if (beat)
        beatCnt <= beatCnt + 2'd1;
      if (wrBeat) begin
        dwValid[beatDw] <= 1'b1;
        if (beatErr)
          errQ <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/p405s_icu_fill_ctl.sv
// ICU miss to PLB read line-fill sequencer. Build option P405S_ICU_FILL_CRITWORD_EN
// makes crit_valid pulse on the first (target) doubleword instead of at line completion.
module p405s_icu_fill_ctl #(
  parameter int LINE_DW = 4
) (
  input  logic        CB,
  input  logic        RST_ResetCore,
  input  logic        miss_req,
  input  logic [0:29] miss_addr,
  input  logic        miss_cacheable,
  input  logic        miss_u0attr,
  input  logic [0:1]  miss_priority,
  input  logic        miss_cancel,
  output logic        C405_icsRequest,
  output logic [0:29] C405_icsABus,
  output logic [2:3]  C405_icsTranSize,
  output logic        C405_icsCacheable,
  output logic        C405_icsU0Attr,
  output logic [0:1]  C405_icsPriority,
  output logic        C405_icsAbort,
  input  logic        ICS_c405AddrAck,
  input  logic        ICS_c405RdDAck,
  input  logic [0:63] ICS_c405DBus,
  input  logic [1:3]  ICS_c405RdWrAddr,
  input  logic        ICS_c405Error,
  input  logic        ICS_c405SSize,
  input  logic        ICS_c405IcuBusy,
  output logic        lb_wr_en,
  output logic [0:1]  lb_wr_dw,
  output logic [0:63] lb_wr_data,
  output logic [0:3]  lb_dw_valid,
  output logic        crit_valid,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fill_err
);
  import p405s_icu_pkg::*;

  fillState_t state, stateNext;
  logic       startFill, doneNext;
  logic       cntBeat, wrBeat, lastBeat, errAny;
  logic [1:0] beatCnt;

  // Beat count follows TranSize only; slave size and the odd-word address bit carry no information here.
  logic unusedIn;
  assign unusedIn = ICS_c405SSize ^ ICS_c405RdWrAddr[3];

  assign cntBeat = ICS_c405RdDAck & ((state == FS_DATA) | (state == FS_DRAIN));
  assign wrBeat  = ICS_c405RdDAck & (state == FS_DATA);

  assign lb_wr_en   = wrBeat;
  assign lb_wr_dw   = wrBeat ? ICS_c405RdWrAddr[1:2] : 2'd0;
  assign lb_wr_data = wrBeat ? ICS_c405DBus : 64'd0;

  p405s_icu_fill_cnt #(.LINE_DW(LINE_DW)) uCnt (
    .CB           (CB),
    .RST_ResetCore(RST_ResetCore),
    .start        (startFill),
    .lineFill     (miss_cacheable),
    .beat         (cntBeat),
    .wrBeat       (wrBeat),
    .beatDw       (ICS_c405RdWrAddr[1:2]),
    .beatErr      (ICS_c405Error),
    .beatCnt      (beatCnt),
    .lastBeat     (lastBeat),
    .errAny       (errAny),
    .dwValid      (lb_dw_valid)
  );

  always_comb begin
    stateNext = state;
    startFill = 1'b0;
    doneNext  = 1'b0;
    case (state)
      FS_IDLE:
        if (miss_req & ~ICS_c405IcuBusy & ~miss_cancel) begin
          stateNext = FS_REQ;
          startFill = 1'b1;
        end
      FS_REQ:
        if (ICS_c405AddrAck)
          stateNext = miss_cancel ? FS_DRAIN : FS_DATA;
        else if (miss_cancel)
          stateNext = FS_ABORT;
      FS_ABORT:
        stateNext = FS_IDLE;
      // A final beat that coincides with a cancel completes: the whole line is already in.
      FS_DATA:
        if (lastBeat) begin
          stateNext = FS_IDLE;
          doneNext  = 1'b1;
        end else if (miss_cancel) begin
          stateNext = FS_DRAIN;
        end
      FS_DRAIN:
        if (lastBeat)
          stateNext = FS_IDLE;
      default:
        stateNext = FS_IDLE;
    endcase
  end

  always_ff @(posedge CB) begin
    if (RST_ResetCore) begin
      state             <= FS_IDLE;
      C405_icsRequest   <= 1'b0;
      C405_icsAbort     <= 1'b0;
      C405_icsABus      <= '0;
      C405_icsTranSize  <= '0;
      C405_icsCacheable <= 1'b0;
      C405_icsU0Attr    <= 1'b0;
      C405_icsPriority  <= '0;
      fill_busy         <= 1'b0;
      fill_done         <= 1'b0;
      fill_err          <= 1'b0;
    end else begin
      state           <= stateNext;
      C405_icsRequest <= (stateNext == FS_REQ);
      C405_icsAbort   <= (stateNext == FS_ABORT);
      fill_busy       <= (stateNext != FS_IDLE);
      fill_done       <= doneNext;
      fill_err        <= doneNext & errAny;
      // Target word first: the address goes out unaligned.
      if (startFill) begin
        C405_icsABus      <= miss_addr;
        C405_icsTranSize  <= miss_cacheable ? TRANSIZE_LINE8 : TRANSIZE_SGL;
        C405_icsCacheable <= miss_cacheable;
        C405_icsU0Attr    <= miss_u0attr;
        C405_icsPriority  <= miss_priority;
      end
    end
  end

`ifdef P405S_ICU_FILL_CRITWORD_EN
  always_ff @(posedge CB) begin
    if (RST_ResetCore)
      crit_valid <= 1'b0;
    else
      crit_valid <= wrBeat & (beatCnt == 2'd0);
  end
`else
  logic unusedCnt;
  assign unusedCnt = ^beatCnt;

  always_ff @(posedge CB) begin
    if (RST_ResetCore)
      crit_valid <= 1'b0;
    else
      crit_valid <= doneNext & ~errAny;
  end
`endif
endmodule

// File: tb/tb_p405s_icu_fill_ctl.sv
// Directed bench for the ICU line-fill sequencer with hand-computed expectations.
module tb_p405s_icu_fill_ctl;
  logic        CB = 1'b0;
  logic        RST_ResetCore;
  logic        miss_req, miss_cacheable, miss_u0attr, miss_cancel;
  logic [0:29] miss_addr;
  logic [0:1]  miss_priority;
  logic        C405_icsRequest, C405_icsCacheable, C405_icsU0Attr, C405_icsAbort;
  logic [0:29] C405_icsABus;
  logic [2:3]  C405_icsTranSize;
  logic [0:1]  C405_icsPriority;
  logic        ICS_c405AddrAck, ICS_c405RdDAck, ICS_c405Error, ICS_c405SSize, ICS_c405IcuBusy;
  logic [0:63] ICS_c405DBus;
  logic [1:3]  ICS_c405RdWrAddr;
  logic        lb_wr_en, crit_valid, fill_busy, fill_done, fill_err;
  logic [0:1]  lb_wr_dw;
  logic [0:63] lb_wr_data;
  logic [0:3]  lb_dw_valid;

  int total = 0;
  int bad = 0;

  always #5 CB = ~CB;

  p405s_icu_fill_ctl #(.LINE_DW(4)) dut (
    .CB(CB), .RST_ResetCore(RST_ResetCore),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_cacheable(miss_cacheable),
    .miss_u0attr(miss_u0attr), .miss_priority(miss_priority), .miss_cancel(miss_cancel),
    .C405_icsRequest(C405_icsRequest), .C405_icsABus(C405_icsABus),
    .C405_icsTranSize(C405_icsTranSize), .C405_icsCacheable(C405_icsCacheable),
    .C405_icsU0Attr(C405_icsU0Attr), .C405_icsPriority(C405_icsPriority),
    .C405_icsAbort(C405_icsAbort),
    .ICS_c405AddrAck(ICS_c405AddrAck), .ICS_c405RdDAck(ICS_c405RdDAck),
    .ICS_c405DBus(ICS_c405DBus), .ICS_c405RdWrAddr(ICS_c405RdWrAddr),
    .ICS_c405Error(ICS_c405Error), .ICS_c405SSize(ICS_c405SSize),
    .ICS_c405IcuBusy(ICS_c405IcuBusy),
    .lb_wr_en(lb_wr_en), .lb_wr_dw(lb_wr_dw), .lb_wr_data(lb_wr_data),
    .lb_dw_valid(lb_dw_valid), .crit_valid(crit_valid),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CB);
    #1;
  endtask

  task automatic startMiss(input string tag, input logic [29:0] a, input logic c);
    miss_req = 1'b1; miss_addr = a; miss_cacheable = c;
    miss_u0attr = c; miss_priority = 2'b10;
    tick();
    miss_req = 1'b0;
    chk({tag, ".req"},   64'(C405_icsRequest), 64'(1));
    chk({tag, ".abus"},  64'(C405_icsABus), 64'(a));
    chk({tag, ".tsize"}, 64'(C405_icsTranSize), c ? 64'(2) : 64'(0));
    chk({tag, ".cach"},  64'(C405_icsCacheable), 64'(c));
    chk({tag, ".u0"},    64'(C405_icsU0Attr), 64'(c));
    chk({tag, ".prio"},  64'(C405_icsPriority), 64'(2));
    chk({tag, ".busy"},  64'(fill_busy), 64'(1));
    chk({tag, ".vclr"},  64'(lb_dw_valid), 64'(0));
  endtask

  task automatic ack(input string tag);
    ICS_c405AddrAck = 1'b1;
    tick();
    ICS_c405AddrAck = 1'b0;
    chk({tag, ".reqfall"}, 64'(C405_icsRequest), 64'(0));
  endtask

  task automatic beat(input string tag, input logic [2:0] wa, input logic [63:0] d,
                      input logic e, input logic expWr, input logic [1:0] expDw);
    ICS_c405RdDAck = 1'b1; ICS_c405RdWrAddr = wa; ICS_c405DBus = d; ICS_c405Error = e;
    #1;
    chk({tag, ".wen"}, 64'(lb_wr_en), 64'(expWr));
    if (expWr) begin
      chk({tag, ".wdw"},  64'(lb_wr_dw), 64'(expDw));
      chk({tag, ".wdat"}, 64'(lb_wr_data), d);
    end
    @(posedge CB);
    #1;
    ICS_c405RdDAck = 1'b0; ICS_c405Error = 1'b0; ICS_c405DBus = '0;
  endtask

  task automatic fill4(input string tag, input logic [11:0] was, input logic [7:0] dws,
                       input logic [15:0] vsteps, input logic [3:0] errs);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("%s.b%0d", tag, i), was[11-3*i -: 3],
           64'(i + 1) * 64'h0101_0101_0101_0101, errs[3-i], 1'b1, dws[7-2*i -: 2]);
      chk($sformatf("%s.v%0d", tag, i),    64'(lb_dw_valid), 64'(vsteps[15-4*i -: 4]));
      chk($sformatf("%s.done%0d", tag, i), 64'(fill_done), 64'(i == 3));
      chk($sformatf("%s.busy%0d", tag, i), 64'(fill_busy), 64'(i != 3));
      if (i == 3) chk({tag, ".err"}, 64'(fill_err), 64'(errs != 4'd0));
`ifdef P405S_ICU_FILL_CRITWORD_EN
      chk($sformatf("%s.crit%0d", tag, i), 64'(crit_valid), 64'(i == 0));
`else
      chk($sformatf("%s.crit%0d", tag, i), 64'(crit_valid), 64'((i == 3) && (errs == 4'd0)));
`endif
    end
    tick();
    chk({tag, ".donefall"}, 64'(fill_done), 64'(0));
  endtask

  initial begin
    RST_ResetCore = 1'b1;
    miss_req = 0; miss_addr = '0; miss_cacheable = 0; miss_u0attr = 0;
    miss_priority = '0; miss_cancel = 0;
    ICS_c405AddrAck = 0; ICS_c405RdDAck = 0; ICS_c405DBus = '0; ICS_c405RdWrAddr = '0;
    ICS_c405Error = 0; ICS_c405SSize = 0; ICS_c405IcuBusy = 0;
    tick(); tick();
    chk("rst.req",   64'(C405_icsRequest), 64'(0));
    chk("rst.abort", 64'(C405_icsAbort), 64'(0));
    chk("rst.busy",  64'(fill_busy), 64'(0));
    chk("rst.done",  64'(fill_done), 64'(0));
    chk("rst.valid", 64'(lb_dw_valid), 64'(0));
    chk("rst.crit",  64'(crit_valid), 64'(0));
    chk("rst.abus",  64'(C405_icsABus), 64'(0));
    RST_ResetCore = 1'b0;
    tick();

    // Entry is blocked by a busy synchronizer and by a concurrent cancel
    miss_req = 1; miss_addr = 30'h100; ICS_c405IcuBusy = 1;
    tick();
    chk("gate.busy.req", 64'(C405_icsRequest), 64'(0));
    ICS_c405IcuBusy = 0; miss_cancel = 1;
    tick();
    chk("gate.cancel.req", 64'(C405_icsRequest), 64'(0));
    chk("gate.cancel.busy", 64'(fill_busy), 64'(0));
    miss_req = 0; miss_cancel = 0;

    // Aligned cacheable line; request held across an un-acked cycle
    startMiss("t1", 30'h100, 1'b1);
    tick();
    chk("t1.reqhold", 64'(C405_icsRequest), 64'(1));
    ack("t1");
    fill4("t1", {3'd0, 3'd2, 3'd4, 3'd6}, {2'd0, 2'd1, 2'd2, 2'd3},
          {4'b1000, 4'b1100, 4'b1110, 4'b1111}, 4'b0000);

    // Target-word-first line
    startMiss("t2", 30'h105, 1'b1);
    ack("t2");
    fill4("t2", {3'd4, 3'd6, 3'd0, 3'd2}, {2'd2, 2'd3, 2'd0, 2'd1},
          {4'b0010, 4'b0011, 4'b1011, 4'b1111}, 4'b0000);

    // Non-cacheable single beat
    startMiss("t3", 30'h007, 1'b0);
    ack("t3");
    beat("t3.b0", 3'd6, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, 2'd3);
    chk("t3.done",  64'(fill_done), 64'(1));
    chk("t3.err",   64'(fill_err), 64'(0));
    chk("t3.busy",  64'(fill_busy), 64'(0));
    chk("t3.valid", 64'(lb_dw_valid), 64'(4'b0001));
    chk("t3.crit",  64'(crit_valid), 64'(1));

    // Cancel in REQ before AddrAck
    startMiss("t4", 30'h040, 1'b1);
    miss_cancel = 1;
    tick();
    miss_cancel = 0;
    chk("t4.abort", 64'(C405_icsAbort), 64'(1));
    chk("t4.req",   64'(C405_icsRequest), 64'(0));
    chk("t4.busy",  64'(fill_busy), 64'(1));
    chk("t4.done",  64'(fill_done), 64'(0));
    tick();
    chk("t4.abortfall", 64'(C405_icsAbort), 64'(0));
    chk("t4.idle",      64'(fill_busy), 64'(0));
    chk("t4.done2",     64'(fill_done), 64'(0));

    // Cancel after the first beat: remaining three are drained silently
    startMiss("t5", 30'h080, 1'b1);
    ack("t5");
    beat("t5.b0", 3'd0, 64'h1, 1'b0, 1'b1, 2'd0);
    miss_cancel = 1;
    tick();
    miss_cancel = 0;
    chk("t5.busyc", 64'(fill_busy), 64'(1));
    for (int i = 1; i < 4; i++) begin
      beat($sformatf("t5.d%0d", i), 3'(2 * i), 64'(i), 1'b0, 1'b0, 2'd0);
      chk($sformatf("t5.busy%0d", i), 64'(fill_busy), 64'(i != 3));
      chk($sformatf("t5.done%0d", i), 64'(fill_done), 64'(0));
      chk($sformatf("t5.v%0d", i),    64'(lb_dw_valid), 64'(4'b1000));
    end
    tick();
    chk("t5.donelate", 64'(fill_done), 64'(0));

    // Error on beat 2 of 4
    startMiss("t6", 30'h0C0, 1'b1);
    ack("t6");
    fill4("t6", {3'd0, 3'd2, 3'd4, 3'd6}, {2'd0, 2'd1, 2'd2, 2'd3},
          {4'b1000, 4'b1100, 4'b1110, 4'b1111}, 4'b0100);

    // Reset in the middle of DATA
    startMiss("t7", 30'h0E0, 1'b1);
    ack("t7");
    beat("t7.b0", 3'd0, 64'h77, 1'b0, 1'b1, 2'd0);
    RST_ResetCore = 1;
    tick();
    RST_ResetCore = 0;
    chk("t7.req",   64'(C405_icsRequest), 64'(0));
    chk("t7.abort", 64'(C405_icsAbort), 64'(0));
    chk("t7.busy",  64'(fill_busy), 64'(0));
    chk("t7.done",  64'(fill_done), 64'(0));
    chk("t7.err",   64'(fill_err), 64'(0));
    chk("t7.valid", 64'(lb_dw_valid), 64'(0));
    chk("t7.crit",  64'(crit_valid), 64'(0));
    chk("t7.tsize", 64'(C405_icsTranSize), 64'(0));
    beat("t7.stray", 3'd2, 64'h5, 1'b0, 1'b0, 2'd0);
    chk("t7.stray.busy", 64'(fill_busy), 64'(0));
    chk("t7.stray.done", 64'(fill_done), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/p405s_icu_fill_ctl.md
# p405s_icu_fill_ctl

Instruction-side line-fill sequencer for the 405 core. It sits directly upstream of the ICU PLB synchronizer. It converts an ICU miss into a PLB read request on the `C405_ics*` bus and collects the returned doubleword beats from `ICS_c405*`. It writes those beats into the ICU line buffer with per-doubleword valid tracking and handles cancellation and bus errors.

## Interface
Parameters:
- `LINE_DW`, 4: doublewords per cache line; fixed at 4 (32-byte line).

Ports:
- `CB`  in  1  core clock; the only clock.
- `RST_ResetCore`  in  1  synchronous, active-high reset.
- `miss_req`  in  1  ICU requests a fill; sampled only in IDLE.
- `miss_addr`  in  [0:29]  word address of the missed fetch.
- `miss_cacheable`  in  1  1 = 8-word line fill; 0 = single-beat fetch.
- `miss_u0attr`  in  1  passed through to the request.
- `miss_priority`  in  [0:1]  passed through to the request.
- `miss_cancel`  in  1  ICU flush; cancels the fill in progress.
- `C405_icsRequest`, `C405_icsABus[0:29]`, `C405_icsTranSize[2:3]`, `C405_icsCacheable`, `C405_icsU0Attr`, `C405_icsPriority[0:1]`, `C405_icsAbort`  out  request to the synchronizer.
- `ICS_c405AddrAck`, `ICS_c405RdDAck`, `ICS_c405DBus[0:63]`, `ICS_c405RdWrAddr[1:3]`, `ICS_c405Error`, `ICS_c405SSize`, `ICS_c405IcuBusy`  in  response from the synchronizer.
- `lb_wr_en`  out  1  line-buffer write strobe.
- `lb_wr_dw`  out  [0:1]  doubleword index within the line.
- `lb_wr_data`  out  [0:63]  write data.
- `lb_dw_valid`  out  [0:3]  per-doubleword valid bits for the current line.
- `crit_valid`  out  1  critical doubleword is available.
- `fill_busy`  out  1  high in every state except IDLE.
- `fill_done`  out  1  one-cycle pulse when the fill completes.
- `fill_err`  out  1  qualifies `fill_done`: at least one beat returned with an error.

## Operation
- States: IDLE, REQ, DATA, DRAIN, ABORT.
- **IDLE**
  - Entry condition: `miss_req & ~ICS_c405IcuBusy & ~miss_cancel`.
  - On entry, capture the attributes and go to REQ.
  - `C405_icsABus` = `miss_addr`. Target word first: the low 3 address bits are kept, not aligned.
  - `C405_icsTranSize` = 2'b10 if cacheable, else 2'b00.
  - Beats expected: 4 if cacheable, 1 if not.
  - Clear `lb_dw_valid`.
- **REQ**
  - `C405_icsRequest`=1 and all attributes are held stable.
  - `ICS_c405AddrAck` → DATA.
  - `miss_cancel` without AddrAck in the same cycle → ABORT.
  - `miss_cancel` together with AddrAck → DRAIN, because the PLB owns the transfer.
- **ABORT**
  - One cycle with `C405_icsAbort`=1 and Request=0, then IDLE.
  - No `fill_done` is issued.
- **DATA**
  - On each `ICS_c405RdDAck`: `lb_wr_en`=1, `lb_wr_dw`=`ICS_c405RdWrAddr[1:2]`, `lb_wr_data`=`ICS_c405DBus`.
  - On the same beat, set `lb_dw_valid[RdWrAddr[1:2]]` and increment the 2-bit beat counter.
  - If `ICS_c405Error` is high on that beat, set the sticky error flag.
  - After the last beat: `fill_done`=1, `fill_err`=sticky flag, go to IDLE.
  - `miss_cancel` in DATA → DRAIN.
- **DRAIN**
  - Count the remaining beats with `lb_wr_en` suppressed.
  - Return to IDLE with no `fill_done`.
- `miss_cancel` is ignored in IDLE.
- `ICS_c405SSize` is ignored; the beat count depends only on TranSize.
- Beat counter arithmetic: 2-bit, wraps 3→0. Completion is detected at count == expected−1 coincident with RdDAck.

## Timing
- All outputs are registered except the `lb_wr_*` signals, which are combinational from RdDAck, RdWrAddr and DBus in DATA.
- `C405_icsRequest` rises 1 cycle after `miss_req` is sampled in IDLE.
- `C405_icsRequest` falls in the cycle after AddrAck is sampled.
- Data beats can arrive back-to-back, one per cycle. A beat in the same cycle as AddrAck is not legal and is not handled.
- `fill_done` is registered: it asserts 1 cycle after the final RdDAck.
- `fill_busy` deasserts in the same cycle as `fill_done`.
- A new `miss_req` is accepted in that same cycle.
- Reset values: all outputs 0, state IDLE, counter 0, sticky error 0.
- Reset in the middle of a fill returns to IDLE immediately. No Abort pulse and no `fill_done` are issued.

## Configuration
- `P405S_ICU_FILL_CRITWORD_EN`
  - Defined: `crit_valid` is a registered pulse one cycle after the first beat, which is the target doubleword. The ICU may restart before the line completes.
  - Undefined: `crit_valid` equals `fill_done & ~fill_err`, so there is no early restart.

## Structure
- Shared package `p405s_icu_pkg` holds:
  - the state encoding;
  - the `TRANSIZE_LINE8`=2'b10 and `TRANSIZE_SGL`=2'b00 constants;
  - `LINE_DW`.
- One natural sub-module: `p405s_icu_fill_cnt`, the beat counter plus the valid-mask and sticky-error register.

## Test plan
- Cacheable miss at `miss_addr`=30'h100 followed by 4 RdDAcks with RdWrAddr 0,2,4,6:
  - Request high for exactly the cycles up to AddrAck; TranSize=10.
  - `lb_dw_valid` steps 1000→1100→1110→1111.
  - `fill_done`=1 and `fill_err`=0 one cycle after the last beat.
- Target-first cacheable miss at `miss_addr`=30'h105 with beats at RdWrAddr 4,6,0,2:
  - `lb_wr_dw` = 2,3,0,1.
  - With the macro defined, `crit_valid` pulses 1 cycle after beat 1.
- Non-cacheable miss: TranSize=00; a single beat gives `fill_done` after 1 beat.
- `miss_cancel` in REQ before AddrAck:
  - Abort is high for 1 cycle, Request is 0, the block returns to IDLE, and there is no `fill_done`.
- `miss_cancel` after AddrAck with 3 beats still to come:
  - No `lb_wr_en`, no `fill_done`; `fill_busy` stays high until the 3rd beat.
- `ICS_c405Error` on beat 2 of 4, plus `RST_ResetCore` mid-DATA in a separate run:
  - Error run: `fill_done`=1 with `fill_err`=1.
  - Reset run: all outputs are 0 on the next cycle.
